// File: rtl/fifo_reader_if.sv
// Interface bundling the fifo_reader control, FIFO read port and output stream.
// The master modport is the reader itself; the slave modport is its environment.
interface fifo_reader_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic              fifo_rd;
  logic              fifo_wr;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    input  start, len, fifo_wr, fifo_empty, fifo_dout, m_ready,
    output busy, done, fifo_rd, m_valid, m_data
  );

  modport slave (
    output start, len, fifo_wr, fifo_empty, fifo_dout, m_ready,
    input  busy, done, fifo_rd, m_valid, m_data
  );
endinterface

// File: rtl/fifo_reader.sv
// Read-side controller for the 8-bit, 16-deep synchronous FIFO. Pops a programmed
// number of words, absorbs the FIFO's one-cycle read latency and write-over-read
// priority, and re-presents the words on a valid/ready stream via a 2-entry buffer.
module fifo_reader #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
) (
  input  logic           clk,
  input  logic           rst,   // asynchronous, active-low
  fifo_reader_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  pop_left_q, pop_left_d;
  logic [LEN_W-1:0]  deliv_left_q, deliv_left_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;   // head of the output buffer
  logic [DATA_W-1:0] buf1_q, buf1_d;   // second entry

  logic              hs;
  logic              rd;
  logic              pop_ok;
  logic [2:0]        fill_after;

  // Pop request: only ask when the buffer can still take the word after this cycle's handshake.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later lines see the freshly computed value.
    hs         = (occ_q != 2'd0) && bus.m_ready;
    fill_after = {1'b0, occ_q} + 3'(inflight_q) - 3'(hs);
    rd         = (state_q == RUN) && (pop_left_q != '0) && !bus.fifo_empty
                 && (fill_after < 3'd2);
    // A same-cycle FIFO write wins, so the pop is dropped and retried next cycle.
    pop_ok     = rd && !bus.fifo_wr;
  end

  // Next-state, counters and done pulse.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d      = state_q;
    pop_left_d   = pop_left_q;
    deliv_left_d = deliv_left_q;
    done_d       = 1'b0;
    inflight_d   = pop_ok;

    if (hs && (deliv_left_q != '0)) begin
      deliv_left_d = deliv_left_q - LEN_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            state_d      = RUN;
            pop_left_d   = bus.len;
            deliv_left_d = bus.len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (pop_ok) begin
          pop_left_d = pop_left_q - LEN_W'(1);
        end
        if (pop_left_d == '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (deliv_left_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output buffer: capture the in-flight word at the tail, shift on handshake.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    case ({inflight_q, hs})
      2'b11: begin
        // Capture and handshake together: occupancy unchanged, order preserved.
        if (occ_q == 2'd1) begin
          buf0_d = bus.fifo_dout;
        end else begin
          buf0_d = buf1_q;
          buf1_d = bus.fifo_dout;
        end
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) begin
          buf0_d = bus.fifo_dout;
        end else begin
          buf1_d = bus.fifo_dout;
        end
        occ_d = occ_q + 2'd1;
      end
      default: ;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pop_left_q   <= '0;
      deliv_left_q <= '0;
      inflight_q   <= 1'b0;
      done_q       <= 1'b0;
      occ_q        <= 2'd0;
      // NOTE: the two buffer entries are reset because m_data must read 0 during reset.
      buf0_q       <= '0;
      buf1_q       <= '0;
    end else begin
      state_q      <= state_d;
      pop_left_q   <= pop_left_d;
      deliv_left_q <= deliv_left_d;
      inflight_q   <= inflight_d;
      done_q       <= done_d;
      occ_q        <= occ_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
    end
  end

  assign bus.fifo_rd = rd;
  assign bus.m_valid = (occ_q != 2'd0);
  assign bus.m_data  = buf0_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed testbench for fifo_reader with a behavioural model of the 16-deep FIFO
// (registered read data, write wins over read).
module tb_fifo_reader;

  logic clk;
  logic rst;
  logic [7:0] fifo_wdata;

  fifo_reader_if #(.DATA_W(8), .LEN_W(5)) bif ();

  fifo_reader #(.DATA_W(8), .LEN_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // FIFO model: a write wins; otherwise an accepted pop presents data after the edge.
  logic [7:0] fq[$];
  always @(posedge clk) begin
    if (bif.fifo_wr) fq.push_back(fifo_wdata);
    else if (bif.fifo_rd && fq.size() != 0) bif.fifo_dout <= fq.pop_front();
    bif.fifo_empty <= (fq.size() == 0);
  end

  // Monitor, sampled on the falling edge (between active edges).
  int         cyc      = 0;
  int         rd_cnt   = 0;
  int         drop_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] got[$];
  int         rd_cyc[$];
  int         hs_cyc[$];
  int         done_cyc[$];
  logic       done_busy[$];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      if (bif.fifo_rd) begin
        rd_cnt <= rd_cnt + 1;
        rd_cyc.push_back(cyc);
      end
      if (bif.fifo_rd && bif.fifo_wr) drop_cnt <= drop_cnt + 1;
      if (bif.m_valid && bif.m_ready) begin
        got.push_back(bif.m_data);
        hs_cyc.push_back(cyc);
      end
      if (bif.done) begin
        done_cnt <= done_cnt + 1;
        done_cyc.push_back(cyc);
        done_busy.push_back(bif.busy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    bif.fifo_wr = 1'b1;
    fifo_wdata  = d;
    tick();
    bif.fifo_wr = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] l);
    bif.start = 1'b1;
    bif.len   = l;
    tick();
    bif.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == d0) begin
      total++;
      $display("FAIL %s: done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    int gb;
    #2 rst = 1'b0;
    #1;
    total++; if (bif.busy    !== 1'b0)  $display("FAIL rst_busy: got %b want 0", bif.busy);    else passed++;
    total++; if (bif.done    !== 1'b0)  $display("FAIL rst_done: got %b want 0", bif.done);    else passed++;
    total++; if (bif.fifo_rd !== 1'b0)  $display("FAIL rst_rd: got %b want 0", bif.fifo_rd);   else passed++;
    total++; if (bif.m_valid !== 1'b0)  $display("FAIL rst_valid: got %b want 0", bif.m_valid); else passed++;
    total++; if (bif.m_data  !== 8'h00) $display("FAIL rst_data: got %h want 00", bif.m_data); else passed++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    // Mid-run reset: two words popped, one buffered, one left in the FIFO.
    push_word(8'hB0); push_word(8'hB1); push_word(8'hB2);
    pulse_start(5'd3);
    tick(); tick();
    total++; if (bif.m_valid !== 1'b1)  $display("FAIL mid_valid: got %b want 1", bif.m_valid); else passed++;
    total++; if (bif.m_data  !== 8'hB0) $display("FAIL mid_data: got %h want b0", bif.m_data); else passed++;
    rst = 1'b0;
    #1;
    total++; if (bif.busy    !== 1'b0)  $display("FAIL mid_rst_busy: got %b want 0", bif.busy);    else passed++;
    total++; if (bif.fifo_rd !== 1'b0)  $display("FAIL mid_rst_rd: got %b want 0", bif.fifo_rd);   else passed++;
    total++; if (bif.m_valid !== 1'b0)  $display("FAIL mid_rst_valid: got %b want 0", bif.m_valid); else passed++;
    total++; if (bif.m_data  !== 8'h00) $display("FAIL mid_rst_data: got %h want 00", bif.m_data); else passed++;
    tick();
    rst = 1'b1;
    tick();
    // The untouched FIFO word B2 is the next one delivered.
    bif.m_ready = 1'b1;
    gb = got.size();
    pulse_start(5'd1);
    wait_done("rst_drain", 20);
    tick();
    total++; if (got.size() - gb !== 1) $display("FAIL rst_drain_cnt: got %0d want 1", got.size() - gb); else passed++;
    total++; if (got[gb] !== 8'hB2)     $display("FAIL rst_drain_data: got %h want b2", got[gb]);      else passed++;
  endtask

  task automatic test_basic();
    int rb, hb, db, gb, r0;
    push_word(8'hA0); push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
    bif.m_ready = 1'b1;
    rb = rd_cyc.size(); hb = hs_cyc.size(); db = done_cyc.size(); gb = got.size();
    pulse_start(5'd4);
    wait_done("basic", 40);
    repeat (3) tick();
    total++; if (rd_cyc.size() - rb !== 4) $display("FAIL basic_rd_cnt: got %0d want 4", rd_cyc.size() - rb); else passed++;
    r0 = rd_cyc[rb];
    for (int i = 1; i < 4; i++) begin
      total++; if (rd_cyc[rb+i] !== r0 + i) $display("FAIL basic_rd_cyc%0d: got %0d want %0d", i, rd_cyc[rb+i], r0 + i); else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (hs_cyc[hb+i] !== r0 + 2 + i) $display("FAIL basic_hs_cyc%0d: got %0d want %0d", i, hs_cyc[hb+i], r0 + 2 + i); else passed++;
      total++; if (got[gb+i] !== 8'hA0 + 8'(i)) $display("FAIL basic_data%0d: got %h want %h", i, got[gb+i], 8'hA0 + 8'(i)); else passed++;
    end
    total++; if (done_cyc.size() - db !== 1)     $display("FAIL basic_done_cnt: got %0d want 1", done_cyc.size() - db); else passed++;
    total++; if (done_cyc[db] !== r0 + 6)        $display("FAIL basic_done_cyc: got %0d want %0d", done_cyc[db], r0 + 6); else passed++;
    total++; if (done_busy[db] !== 1'b0)         $display("FAIL basic_busy_at_done: got %b want 0", done_busy[db]); else passed++;
  endtask

  task automatic test_backpressure();
    int r0, gb;
    push_word(8'hC0); push_word(8'hC1); push_word(8'hC2); push_word(8'hC3);
    bif.m_ready = 1'b0;
    r0 = rd_cnt; gb = got.size();
    pulse_start(5'd4);
    repeat (8) tick();
    total++; if (rd_cnt - r0 !== 2)     $display("FAIL bp_pops: got %0d want 2", rd_cnt - r0);    else passed++;
    total++; if (bif.fifo_rd !== 1'b0)  $display("FAIL bp_rd: got %b want 0", bif.fifo_rd);       else passed++;
    total++; if (bif.m_valid !== 1'b1)  $display("FAIL bp_valid: got %b want 1", bif.m_valid);    else passed++;
    total++; if (bif.m_data  !== 8'hC0) $display("FAIL bp_hold: got %h want c0", bif.m_data);     else passed++;
    bif.m_ready = 1'b1;
    wait_done("bp", 40);
    tick();
    total++; if (got.size() - gb !== 4) $display("FAIL bp_cnt: got %0d want 4", got.size() - gb); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (got[gb+i] !== 8'hC0 + 8'(i)) $display("FAIL bp_data%0d: got %h want %h", i, got[gb+i], 8'hC0 + 8'(i)); else passed++;
    end
  endtask

  task automatic test_collision();
    int gb, d0, dn0;
    logic [7:0] exp_w [6] = '{8'hD0, 8'hD1, 8'hD2, 8'hE0, 8'hE1, 8'hE2};
    push_word(8'hD0); push_word(8'hD1); push_word(8'hD2);
    bif.m_ready = 1'b1;
    gb = got.size(); d0 = drop_cnt; dn0 = done_cnt;
    pulse_start(5'd6);
    for (int i = 0; i < 6; i++) begin
      bif.fifo_wr = (i % 2 == 0);
      fifo_wdata  = 8'hE0 + 8'(i / 2);
      tick();
    end
    bif.fifo_wr = 1'b0;
    wait_done("coll", 60);
    repeat (3) tick();
    total++; if (drop_cnt - d0 == 0)      $display("FAIL coll_drops: got %0d want nonzero", drop_cnt - d0); else passed++;
    total++; if (got.size() - gb !== 6)   $display("FAIL coll_cnt: got %0d want 6", got.size() - gb);     else passed++;
    for (int i = 0; i < 6; i++) begin
      total++; if (got[gb+i] !== exp_w[i]) $display("FAIL coll_data%0d: got %h want %h", i, got[gb+i], exp_w[i]); else passed++;
    end
    total++; if (done_cnt - dn0 !== 1)    $display("FAIL coll_done_cnt: got %0d want 1", done_cnt - dn0); else passed++;
  endtask

  task automatic test_empty_stall();
    int gb, dn0;
    push_word(8'hF0); push_word(8'hF1);
    bif.m_ready = 1'b1;
    gb = got.size(); dn0 = done_cnt;
    pulse_start(5'd5);
    repeat (10) tick();
    total++; if (got.size() - gb !== 2) $display("FAIL stall_cnt: got %0d want 2", got.size() - gb); else passed++;
    total++; if (bif.busy    !== 1'b1)  $display("FAIL stall_busy: got %b want 1", bif.busy);        else passed++;
    total++; if (bif.fifo_rd !== 1'b0)  $display("FAIL stall_rd: got %b want 0", bif.fifo_rd);      else passed++;
    total++; if (done_cnt - dn0 !== 0)  $display("FAIL stall_done: got %0d want 0", done_cnt - dn0); else passed++;
    push_word(8'hF2); push_word(8'hF3); push_word(8'hF4);
    wait_done("stall", 40);
    repeat (2) tick();
    total++; if (got.size() - gb !== 5) $display("FAIL stall_total: got %0d want 5", got.size() - gb); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++; if (got[gb+i] !== 8'hF0 + 8'(i)) $display("FAIL stall_data%0d: got %h want %h", i, got[gb+i], 8'hF0 + 8'(i)); else passed++;
    end
    total++; if (bif.busy !== 1'b0)     $display("FAIL stall_idle: got %b want 0", bif.busy); else passed++;
  endtask

  task automatic test_edge();
    int r0, gb, dn0;
    r0 = rd_cnt;
    pulse_start(5'd0);
    total++; if (bif.done !== 1'b1) $display("FAIL len0_done: got %b want 1", bif.done); else passed++;
    total++; if (bif.busy !== 1'b0) $display("FAIL len0_busy: got %b want 0", bif.busy); else passed++;
    tick();
    total++; if (bif.done !== 1'b0) $display("FAIL len0_pulse: got %b want 0", bif.done); else passed++;
    total++; if (rd_cnt - r0 !== 0) $display("FAIL len0_rd: got %0d want 0", rd_cnt - r0); else passed++;
    // A start while busy must not reload the length.
    push_word(8'h90); push_word(8'h91); push_word(8'h92);
    bif.m_ready = 1'b0;
    gb = got.size(); dn0 = done_cnt;
    pulse_start(5'd2);
    total++; if (bif.busy !== 1'b1) $display("FAIL busy_start: got %b want 1", bif.busy); else passed++;
    pulse_start(5'd3);
    bif.m_ready = 1'b1;
    wait_done("busy_start", 40);
    repeat (4) tick();
    total++; if (got.size() - gb !== 2) $display("FAIL busy_cnt: got %0d want 2", got.size() - gb); else passed++;
    total++; if (got[gb] !== 8'h90)     $display("FAIL busy_data0: got %h want 90", got[gb]);     else passed++;
    total++; if (got[gb+1] !== 8'h91)   $display("FAIL busy_data1: got %h want 91", got[gb+1]);   else passed++;
    total++; if (done_cnt - dn0 !== 1)  $display("FAIL busy_done: got %0d want 1", done_cnt - dn0); else passed++;
    pulse_start(5'd1);
    wait_done("busy_drain", 20);
    tick();
    total++; if (got[gb+2] !== 8'h92)   $display("FAIL busy_left: got %h want 92", got[gb+2]);    else passed++;
  endtask

  initial begin
    rst         = 1'b1;
    bif.start   = 1'b0;
    bif.len     = '0;
    bif.fifo_wr = 1'b0;
    bif.m_ready = 1'b0;
    fifo_wdata  = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_collision();
    test_empty_stall();
    test_edge();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
